// File: rtl/i2s_apb_regs.sv
// Bus register responder for one I2S transceiver: CTRL word, TX sample FIFO, RX sample FIFO, STATUS.
// Latency: reads return data one cycle after the access; CTRL writes take effect on the next cycle.
// Backpressure: none on the bus; TX push while full or RX pop while empty drops the access and flags pslverr.
module i2s_apb_regs #(
  parameter logic [31:0] OFFSET = 32'h0,
  parameter int          DEPTH  = 8,
  parameter int          DW     = 32
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [31:0]   paddr,
  input  logic [31:0]   pwdata,
  output logic [31:0]   prdata,
  output logic          pslverr,
  output logic [31:0]   op,
  output logic [DW-1:0] tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  input  logic [DW-1:0] rx_data,
  input  logic          rx_valid,
  output logic          tx_empty,
  output logic          rx_full
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  // Storage and state
  logic [DW-1:0] tx_mem_q [DEPTH];
  logic [DW-1:0] rx_mem_q [DEPTH];
  ptr_t          tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  ptr_t          rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [31:0]   op_q, op_d, prdata_q, prdata_d;
  logic          pslverr_q, pslverr_d;
  logic          tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d, rx_ovf_q, rx_ovf_d;

  // Decode and FIFO status
  logic          hit, wr_ctrl, wr_tx, rd_rx, wr_stat, rd_hit;
  logic [1:0]    idx;
  ptr_t          tx_cnt, rx_cnt;
  logic          tx_full_w, tx_empty_w, rx_full_w, rx_empty_w;
  logic          tx_pop, tx_push, tx_ovf_set;
  logic          rx_pop, rx_push, rx_unf_set, rx_ovf_set;
  logic [31:0]   status;

  // Address decode, FIFO occupancy and push/pop qualification
  always_comb begin
    hit     = penable && (paddr >= OFFSET) && (paddr <= OFFSET + 32'hF);
    idx     = paddr[3:2];
    wr_ctrl = hit &&  pwrite && (idx == 2'd0);
    wr_tx   = hit &&  pwrite && (idx == 2'd1);
    rd_rx   = hit && !pwrite && (idx == 2'd2);
    wr_stat = hit &&  pwrite && (idx == 2'd3);
    rd_hit  = hit && !pwrite;

    tx_cnt     = tx_wr_q - tx_rd_q;
    rx_cnt     = rx_wr_q - rx_rd_q;
    tx_full_w  = (tx_cnt == ptr_t'(DEPTH));
    tx_empty_w = (tx_cnt == '0);
    rx_full_w  = (rx_cnt == ptr_t'(DEPTH));
    rx_empty_w = (rx_cnt == '0);

    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    tx_pop     = !tx_empty_w && tx_ready;
    tx_push    = wr_tx && (!tx_full_w || tx_pop);
    tx_ovf_set = wr_tx && tx_full_w && !tx_pop;

    // An empty RX FIFO underflows even if a word arrives in the same cycle.
    rx_pop     = rd_rx && !rx_empty_w;
    rx_unf_set = rd_rx && rx_empty_w;
    rx_push    = rx_valid && (!rx_full_w || rx_pop);
    rx_ovf_set = rx_valid && rx_full_w && !rx_pop;

    status = {9'b0, rx_ovf_q, rx_unf_q, tx_ovf_q,
              rx_empty_w, rx_full_w, tx_empty_w, tx_full_w,
              8'(rx_cnt), 8'(tx_cnt)};
  end

  // Next-state: pointers, control word, sticky flags, registered read data and error
  always_comb begin
    tx_wr_d = tx_push ? tx_wr_q + ptr_t'(1) : tx_wr_q;
    tx_rd_d = tx_pop  ? tx_rd_q + ptr_t'(1) : tx_rd_q;
    rx_wr_d = rx_push ? rx_wr_q + ptr_t'(1) : rx_wr_q;
    rx_rd_d = rx_pop  ? rx_rd_q + ptr_t'(1) : rx_rd_q;
    op_d    = wr_ctrl ? pwdata : op_q;

    // Setting wins over a same-cycle write-1-clear.
    tx_ovf_d = tx_ovf_set || (tx_ovf_q && !(wr_stat && pwdata[20]));
    rx_unf_d = rx_unf_set || (rx_unf_q && !(wr_stat && pwdata[21]));
    rx_ovf_d = rx_ovf_set || (rx_ovf_q && !(wr_stat && pwdata[22]));

    prdata_d = '0;
    if (rd_hit) begin
      case (idx)
        2'd0:    prdata_d = op_q;
        2'd2:    prdata_d = rx_pop ? 32'(rx_mem_q[rx_rd_q[AW-1:0]]) : 32'h0;
        2'd3:    prdata_d = status;
        default: prdata_d = '0;
      endcase
    end
    pslverr_d = tx_ovf_set || rx_unf_set;
  end

  // State registers, cleared asynchronously
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      tx_wr_q   <= '0;
      tx_rd_q   <= '0;
      rx_wr_q   <= '0;
      rx_rd_q   <= '0;
      op_q      <= '0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      tx_ovf_q  <= 1'b0;
      rx_unf_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
    end else begin
      tx_wr_q   <= tx_wr_d;
      tx_rd_q   <= tx_rd_d;
      rx_wr_q   <= rx_wr_d;
      rx_rd_q   <= rx_rd_d;
      op_q      <= op_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_unf_q  <= rx_unf_d;
      rx_ovf_q  <= rx_ovf_d;
    end
  end

  // Sample storage; contents are only meaningful between the pointers, so no reset
  always_ff @(posedge pclk) begin
    if (tx_push) tx_mem_q[tx_wr_q[AW-1:0]] <= pwdata[DW-1:0];
    if (rx_push) rx_mem_q[rx_wr_q[AW-1:0]] <= rx_data;
  end

  assign prdata   = prdata_q;
  assign pslverr  = pslverr_q;
  assign op       = op_q;
  assign tx_data  = tx_mem_q[tx_rd_q[AW-1:0]];
  assign tx_valid = !tx_empty_w;
  assign tx_empty = tx_empty_w;
  assign rx_full  = rx_full_w;

endmodule

// File: tb/tb_i2s_apb_regs.sv
module tb_i2s_apb_regs;

  localparam logic [31:0] A_CTRL = 32'h10;
  localparam logic [31:0] A_TX   = 32'h14;
  localparam logic [31:0] A_RX   = 32'h18;
  localparam logic [31:0] A_ST   = 32'h1C;

  logic        pclk = 1'b0;
  logic        preset = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pslverr;
  logic [31:0] op;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        tx_empty;
  logic        rx_full;

  int checks = 0;
  int errors = 0;

  i2s_apb_regs #(.OFFSET(32'h10), .DEPTH(8), .DW(32)) dut (
    .pclk(pclk), .preset(preset), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pslverr(pslverr),
    .op(op), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_empty(tx_empty), .rx_full(rx_full)
  );

  always #5 pclk = ~pclk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge pclk);
    @(negedge pclk);
  endtask

  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d);
    penable = 1'b1; pwrite = w; paddr = a; pwdata = d;
    step();
    penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge pclk);
    checks++; if (op !== 32'h0) begin errors++; $display("FAIL reset_op got %h exp 0", op); end
    checks++; if (prdata !== 32'h0 || pslverr !== 1'b0) begin errors++; $display("FAIL reset_bus got prdata=%h pslverr=%b exp 0/0", prdata, pslverr); end
    checks++; if ({tx_empty, rx_full, tx_valid} !== 3'b100) begin errors++; $display("FAIL reset_flags got %b exp 100", {tx_empty, rx_full, tx_valid}); end
    preset = 1'b1;
    step();
  endtask

  task automatic test_ctrl();
    bus(1'b1, A_CTRL, 32'h0000_1A2B);
    checks++; if (op !== 32'h0000_1A2B) begin errors++; $display("FAIL ctrl_write got %h exp 00001a2b", op); end
    bus(1'b1, 32'h0, 32'hDEAD_BEEF);
    checks++; if (op !== 32'h0000_1A2B) begin errors++; $display("FAIL ctrl_miss got %h exp 00001a2b", op); end
    bus(1'b0, A_CTRL, 32'h0);
    checks++; if (prdata !== 32'h0000_1A2B) begin errors++; $display("FAIL ctrl_read got %h exp 00001a2b", prdata); end
    bus(1'b0, 32'h20, 32'h0);
    checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL miss_read got %h exp 0", prdata); end
  endtask

  task automatic test_tx_fill();
    for (int i = 0; i < 8; i++) begin
      bus(1'b1, A_TX, 32'h11 + i);
      if (i == 0) begin
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL tx_valid_rise got %b exp 1", tx_valid); end
      end
    end
    bus(1'b0, A_ST, 32'h0);
    checks++; if (prdata[7:0] !== 8'd8 || prdata[17:16] !== 2'b01) begin errors++; $display("FAIL tx_full_status got %h exp cnt 8 full 1 empty 0", prdata); end
    bus(1'b1, A_TX, 32'h99);
    checks++; if (pslverr !== 1'b1) begin errors++; $display("FAIL tx_ovf_err got %b exp 1", pslverr); end
    bus(1'b0, A_ST, 32'h0);
    checks++; if (prdata[20] !== 1'b1 || prdata[7:0] !== 8'd8 || pslverr !== 1'b0) begin errors++; $display("FAIL tx_ovf_flag got status=%h pslverr=%b exp ovf 1 cnt 8 err 0", prdata, pslverr); end
    bus(1'b0, A_TX, 32'h0);
    checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL txdata_read got %h exp 0", prdata); end
  endtask

  task automatic test_tx_drain();
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (tx_data !== 32'h11 + i || tx_valid !== 1'b1) begin errors++; $display("FAIL tx_drain%0d got %h exp %h", i, tx_data, 32'h11 + i); end
      step();
    end
    step();
    checks++; if (tx_empty !== 1'b1 || tx_valid !== 1'b0) begin errors++; $display("FAIL tx_empty_after got empty=%b valid=%b exp 1/0", tx_empty, tx_valid); end
    tx_ready = 1'b0;
    bus(1'b1, A_ST, 32'h0010_0000);
    bus(1'b0, A_ST, 32'h0);
    checks++; if (prdata[20] !== 1'b0) begin errors++; $display("FAIL tx_ovf_clear got %h exp bit20 0", prdata); end
  endtask

  task automatic test_tx_wrap();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) bus(1'b1, A_TX, 32'h200 + 16 * r + i);
      if (r == 1) begin
        tx_ready = 1'b1;
        bus(1'b1, A_TX, 32'h2FF);
        tx_ready = 1'b0;
        checks++; if (pslverr !== 1'b0) begin errors++; $display("FAIL tx_pushpop_full err got %b exp 0", pslverr); end
        bus(1'b0, A_ST, 32'h0);
        checks++; if (prdata[7:0] !== 8'd8 || prdata[20] !== 1'b0) begin errors++; $display("FAIL tx_pushpop_full status got %h exp cnt 8 ovf 0", prdata); end
      end
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
        logic [31:0] exp;
        exp = 32'h200 + 16 * r + i;
        if (r == 1) exp = (i < 7) ? exp + 32'h1 : 32'h2FF;
        checks++; if (tx_data !== exp) begin errors++; $display("FAIL tx_wrap r%0d i%0d got %h exp %h", r, i, tx_data, exp); end
        step();
      end
      tx_ready = 1'b0;
      checks++; if (tx_empty !== 1'b1) begin errors++; $display("FAIL tx_wrap_empty r%0d got %b exp 1", r, tx_empty); end
    end
  endtask

  task automatic test_rx_back_to_back();
    rx_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      rx_data = 32'hA5A5_0000 + i;
      step();
    end
    rx_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus(1'b0, A_RX, 32'h0);
      if (i < 4) begin
        checks++; if (prdata !== 32'hA5A5_0000 + i || pslverr !== 1'b0) begin errors++; $display("FAIL rx_read%0d got %h err %b exp %h err 0", i, prdata, pslverr, 32'hA5A5_0000 + i); end
      end else begin
        checks++; if (prdata !== 32'h0 || pslverr !== 1'b1) begin errors++; $display("FAIL rx_unf got %h err %b exp 0 err 1", prdata, pslverr); end
      end
    end
    bus(1'b0, A_ST, 32'h0);
    checks++; if (prdata[21] !== 1'b1 || prdata[19] !== 1'b1) begin errors++; $display("FAIL rx_unf_flag got %h exp unf 1 empty 1", prdata); end
    // Pop while empty underflows, but the arriving word is kept.
    rx_valid = 1'b1; rx_data = 32'h77;
    bus(1'b0, A_RX, 32'h0);
    rx_valid = 1'b0;
    checks++; if (prdata !== 32'h0 || pslverr !== 1'b1) begin errors++; $display("FAIL rx_empty_pushpop got %h err %b exp 0 err 1", prdata, pslverr); end
    bus(1'b0, A_RX, 32'h0);
    checks++; if (prdata !== 32'h77 || pslverr !== 1'b0) begin errors++; $display("FAIL rx_retained got %h err %b exp 77 err 0", prdata, pslverr); end
  endtask

  task automatic test_rx_full();
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 32'hB0 + i;
      step();
    end
    rx_valid = 1'b0;
    checks++; if (rx_full !== 1'b1) begin errors++; $display("FAIL rx_full_port got %b exp 1", rx_full); end
    rx_valid = 1'b1; rx_data = 32'hC0;
    bus(1'b0, A_RX, 32'h0);
    rx_valid = 1'b0;
    checks++; if (prdata !== 32'hB0 || pslverr !== 1'b0) begin errors++; $display("FAIL rx_full_pushpop got %h err %b exp b0 err 0", prdata, pslverr); end
    bus(1'b0, A_ST, 32'h0);
    checks++; if (prdata[15:8] !== 8'd8 || prdata[22] !== 1'b0 || prdata[18] !== 1'b1) begin errors++; $display("FAIL rx_full_status got %h exp cnt 8 ovf 0 full 1", prdata); end
    rx_valid = 1'b1; rx_data = 32'hD0;
    step();
    rx_valid = 1'b0;
    bus(1'b0, A_ST, 32'h0);
    checks++; if (prdata[22] !== 1'b1 || prdata[15:8] !== 8'd8) begin errors++; $display("FAIL rx_ovf got %h exp ovf 1 cnt 8", prdata); end
    // Set and write-1-clear in the same cycle: set wins.
    rx_valid = 1'b1; rx_data = 32'hD1;
    bus(1'b1, A_ST, 32'h0040_0000);
    rx_valid = 1'b0;
    bus(1'b0, A_ST, 32'h0);
    checks++; if (prdata[22] !== 1'b1) begin errors++; $display("FAIL sticky_priority got %h exp bit22 1", prdata); end
    bus(1'b1, A_ST, 32'h0070_0000);
    bus(1'b0, A_ST, 32'h0);
    checks++; if (prdata[22:20] !== 3'b000 || prdata[15:8] !== 8'd8) begin errors++; $display("FAIL sticky_clear got %h exp bits22:20 0 cnt 8", prdata); end
    bus(1'b0, A_RX, 32'h0);
    checks++; if (prdata !== 32'hB1) begin errors++; $display("FAIL rx_order got %h exp b1", prdata); end
  endtask

  task automatic test_reset_mid();
    bus(1'b1, A_TX, 32'h55);
    bus(1'b1, A_TX, 32'h56);
    bus(1'b0, A_CTRL, 32'h0);
    penable = 1'b1; pwrite = 1'b1; paddr = A_TX; pwdata = 32'h57;
    #2 preset = 1'b0;
    #1;
    checks++; if (op !== 32'h0 || prdata !== 32'h0 || pslverr !== 1'b0) begin errors++; $display("FAIL async_reset_bus got op=%h prdata=%h err=%b exp 0", op, prdata, pslverr); end
    checks++; if ({tx_empty, rx_full, tx_valid} !== 3'b100) begin errors++; $display("FAIL async_reset_flags got %b exp 100", {tx_empty, rx_full, tx_valid}); end
    step();
    penable = 1'b0; pwrite = 1'b0;
    preset = 1'b1;
    bus(1'b0, A_ST, 32'h0);
    checks++; if (prdata !== 32'h000A_0000) begin errors++; $display("FAIL post_reset_status got %h exp 000a0000", prdata); end
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_tx_fill();
    test_tx_drain();
    test_tx_wrap();
    test_rx_back_to_back();
    test_rx_full();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
